// File: rtl/mips_ex_unit.sv
// mips_ex_unit: EX-stage program counter, ALU with flag/branch resolution and data memory.
// Define DMEM_BYPASS_EN for write-first data-memory reads (default is read-first).
module mips_ex_unit #(
    parameter int DW = 16,
    parameter int MEM_AW = 8
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic [7:0]        alu_i,
    input  logic [DW-1:0]     a_i,
    input  logic [DW-1:0]     b_i,
    input  logic [2:0]        wr_adr_i,
    input  logic [11:0]       cnt_i,
    input  logic [1:0]        flag_i,
    input  logic              haz_i,
    input  logic              mem_wr_i,
    input  logic [MEM_AW-1:0] mem_adr_i,
    input  logic [DW-1:0]     mem_data_i,
    output logic [DW-1:0]     cnt_o,
    output logic [DW-1:0]     result_o,
    output logic              wr_en_o,
    output logic [2:0]        wr_adr_o,
    output logic [2:0]        flag_wr_o,
    output logic              haz_o,
    output logic [DW-1:0]     cnt_new_o,
    output logic [DW-1:0]     mem_rdata_o
);
    localparam logic [7:0] OP_ADD = 8'd1;
    localparam logic [7:0] OP_SUB = 8'd2;
    localparam logic [7:0] OP_AND = 8'd3;
    localparam logic [7:0] OP_OR  = 8'd4;
    localparam logic [7:0] OP_XOR = 8'd5;
    localparam logic [7:0] OP_SHL = 8'd6;
    localparam logic [7:0] OP_SHR = 8'd7;
    localparam logic [7:0] OP_MOV = 8'd8;
    localparam logic [7:0] OP_BEQ = 8'd9;
    localparam logic [7:0] OP_BNE = 8'd10;
    localparam logic [7:0] OP_JMP = 8'd11;

    logic [DW:0]   sum, dif, shl, shr;
    logic [DW-1:0] res, tgt, brt;
    logic          c, we, fw, tk;
    logic [DW-1:0] mem [2**MEM_AW];

    // Extra bit catches carry/borrow; shifts keep the last bit shifted out in the spare position.
    assign sum = {1'b0, a_i} + {1'b0, b_i};
    assign dif = {1'b0, a_i} - {1'b0, b_i};
    assign shl = {1'b0, a_i} << b_i[3:0];
    assign shr = {a_i, 1'b0} >> b_i[3:0];
    assign brt = {{(DW-12){1'b0}}, cnt_i} + DW'(1) + b_i;
    assign we  = !haz_i && (alu_i inside {[OP_ADD:OP_MOV]});
    assign fw  = !haz_i && (alu_i inside {[OP_ADD:OP_SHR]});

    always_comb begin
        res = '0;
        c   = 1'b0;
        tk  = 1'b0;
        tgt = b_i;
        if (!haz_i) begin
            case (alu_i)
                OP_ADD: {c, res} = sum;
                OP_SUB: {c, res} = dif;
                OP_AND: res = a_i & b_i;
                OP_OR:  res = a_i | b_i;
                OP_XOR: res = a_i ^ b_i;
                OP_SHL: {c, res} = shl;
                OP_SHR: {res, c} = shr;
                OP_MOV: res = b_i;
                OP_BEQ: begin tk = flag_i[0];  tgt = brt; end
                OP_BNE: begin tk = !flag_i[0]; tgt = brt; end
                OP_JMP: tk = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            cnt_o     <= '0;
            result_o  <= '0;
            wr_en_o   <= 1'b0;
            wr_adr_o  <= '0;
            flag_wr_o <= '0;
            haz_o     <= 1'b0;
            cnt_new_o <= '0;
        end else begin
            cnt_o     <= haz_o ? cnt_new_o : cnt_o + DW'(1);
            result_o  <= res;
            wr_en_o   <= we;
            wr_adr_o  <= we ? wr_adr_i : 3'd0;
            flag_wr_o <= {fw, fw & c, fw & (res == '0)};
            haz_o     <= tk;
            if (tk)
                cnt_new_o <= tgt;
        end
    end

    // Array is deliberately left out of reset so stored data survives it.
    always_ff @(posedge clk_i) begin
        if (mem_wr_i)
            mem[mem_adr_i] <= mem_data_i;
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst)
            mem_rdata_o <= '0;
`ifdef DMEM_BYPASS_EN
        else
            mem_rdata_o <= mem_wr_i ? mem_data_i : mem[mem_adr_i];
`else
        else
            mem_rdata_o <= mem[mem_adr_i];
`endif
    end
endmodule

// File: tb/tb_mips_ex_unit.sv
// tb_mips_ex_unit: directed plus random checks of mips_ex_unit against an arithmetic reference model.
module tb_mips_ex_unit;
    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  alu_i = '0;
    logic [15:0] a_i = '0, b_i = '0, mem_data_i = '0;
    logic [2:0]  wr_adr_i = '0;
    logic [11:0] cnt_i = '0;
    logic [1:0]  flag_i = '0;
    logic        haz_i = 1'b0, mem_wr_i = 1'b0;
    logic [7:0]  mem_adr_i = '0;
    logic [15:0] cnt_o, result_o, cnt_new_o, mem_rdata_o;
    logic        wr_en_o, haz_o;
    logic [2:0]  wr_adr_o, flag_wr_o;

    mips_ex_unit dut (
        .clk_i(clk_i), .rst(rst), .alu_i(alu_i), .a_i(a_i), .b_i(b_i),
        .wr_adr_i(wr_adr_i), .cnt_i(cnt_i), .flag_i(flag_i), .haz_i(haz_i),
        .mem_wr_i(mem_wr_i), .mem_adr_i(mem_adr_i), .mem_data_i(mem_data_i),
        .cnt_o(cnt_o), .result_o(result_o), .wr_en_o(wr_en_o), .wr_adr_o(wr_adr_o),
        .flag_wr_o(flag_wr_o), .haz_o(haz_o), .cnt_new_o(cnt_new_o), .mem_rdata_o(mem_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0, miscompares = 0;
    int pc = 0, pend_tgt = 0;
    bit pend = 0, fresh = 1;
    int mm [256];
    bit mv [256];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] e);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // One instruction plus one memory access per cycle; expectations come from plain arithmetic.
    task automatic apply(input int op, input int a, input int b, input int wa, input int pci,
                         input int fl, input bit sq, input bit mw, input int ma, input int md);
        int r = 0, c = 0, s = b % 16, tgt = 0, erd = 0;
        bit tk = 0, we = 0, fw = 0, rk = 0;
        if (!sq) begin
            case (op)
                1: begin r = (a + b) % 65536; c = (a + b) > 65535; end
                2: begin r = (a - b + 65536) % 65536; c = a < b; end
                3: r = a & b;
                4: r = a | b;
                5: r = a ^ b;
                6: begin r = (a << s) % 65536; c = s ? (a >> (16 - s)) & 1 : 0; end
                7: begin r = a >> s; c = s ? (a >> (s - 1)) & 1 : 0; end
                8: r = b;
                9: begin tk = fl % 2 == 1; tgt = (pci + 1 + b) % 65536; end
                10: begin tk = fl % 2 == 0; tgt = (pci + 1 + b) % 65536; end
                11: begin tk = 1; tgt = b; end
                default: ;
            endcase
            we = op >= 1 && op <= 8;
            fw = op >= 1 && op <= 7;
        end
`ifdef DMEM_BYPASS_EN
        rk = mw || mv[ma];
        erd = mw ? md : mm[ma];
`else
        rk = mv[ma];
        erd = mm[ma];
`endif
        alu_i = 8'(op); a_i = 16'(a); b_i = 16'(b); wr_adr_i = 3'(wa);
        cnt_i = 12'(pci); flag_i = 2'(fl); haz_i = sq;
        mem_wr_i = mw; mem_adr_i = 8'(ma); mem_data_i = 16'(md);
        pc = pend ? pend_tgt : (pc + 1) % 65536;
        @(posedge clk_i); #1;
        chk("cnt_o", cnt_o, 16'(pc));
        chk("wr_en_o", 16'(wr_en_o), 16'(we));
        chk("flag_wr_o", 16'(flag_wr_o), fw ? 16'({1'b1, c[0], r == 0}) : 16'd0);
        chk("haz_o", 16'(haz_o), 16'(tk));
        if (we || fresh) chk("result_o", result_o, 16'(r));
        if (we || fresh) chk("wr_adr_o", 16'(wr_adr_o), we ? 16'(wa) : 16'd0);
        if (tk || fresh) chk("cnt_new_o", cnt_new_o, 16'(tgt));
        if (rk) chk("mem_rdata_o", mem_rdata_o, 16'(erd));
        if (mw) begin mm[ma] = md; mv[ma] = 1; end
        pend = tk;
        if (tk) pend_tgt = tgt;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst cnt_o", cnt_o, 16'h0);
        chk("rst result_o", result_o, 16'h0);
        chk("rst flags", 16'({wr_en_o, wr_adr_o, flag_wr_o, haz_o}), 16'h0);
        chk("rst cnt_new_o", cnt_new_o, 16'h0);
        chk("rst mem_rdata_o", mem_rdata_o, 16'h0);
        rst = 1'b0;
        repeat (3) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fresh = 0;
        apply(1, 16'hFFFF, 16'h0001, 3, 0, 0, 0, 0, 0, 0);
        apply(2, 16'h0002, 16'h0005, 1, 0, 0, 0, 0, 0, 0);
        apply(7, 16'h0003, 1, 2, 0, 0, 0, 0, 0, 0);
        apply(6, 16'h8001, 1, 4, 0, 0, 0, 0, 0, 0);
        apply(6, 16'h8001, 0, 4, 0, 0, 0, 0, 0, 0);
        apply(3, 16'hF0F0, 16'h0F0F, 5, 0, 0, 0, 0, 0, 0);
        apply(8, 16'h1111, 16'h0000, 6, 0, 0, 0, 0, 0, 0);
        apply(9, 0, 16'hFFFE, 0, 12'h010, 2'b01, 0, 0, 0, 0);
        apply(9, 0, 16'hFFFE, 0, 12'h010, 2'b01, 1, 0, 0, 0);
        apply(1, 5, 5, 7, 0, 0, 1, 0, 0, 0);
        apply(10, 0, 16'h0020, 0, 12'hFFF, 2'b00, 0, 0, 0, 0);
        apply(11, 0, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
        apply(11, 0, 16'h0777, 0, 0, 0, 0, 0, 0, 0);
        apply(9, 0, 3, 0, 5, 2'b10, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 8'h20, 16'hBEEF);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 8'h20, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 8'h20, 16'h1234);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 8'h20, 0);
        apply(11, 0, 16'h0ABC, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid-rst cnt_o", cnt_o, 16'h0);
        chk("mid-rst haz_o", 16'(haz_o), 16'h0);
        chk("mid-rst result_o", result_o, 16'h0);
        chk("mid-rst mem_rdata_o", mem_rdata_o, 16'h0);
        @(posedge clk_i); #1;
        rst = 1'b0;
        pc = 0; pend = 0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 8'h20, 0);
        for (int i = 0; i < 400; i++)
            apply($urandom_range(0, 15), $urandom_range(0, 65535),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 65535),
                  $urandom_range(0, 7), $urandom_range(0, 4095), $urandom_range(0, 3),
                  $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                  $urandom_range(0, 65535));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
